limn2600_cache_fill: RTL and testbench
======================================

# limn2600_cache_fill

Lookup and miss-fill controller in front of the Limn2600 hashed data cache. It accepts word-sized CPU load/store requests and keeps a tag/valid array that uses the same hash index as the cache. It serves hits from the cache read port, and services misses and write-through stores over a single-outstanding memory bus. On completion it writes the word into the cache through the cache's write port.

## Interface
- NUM_ENTRIES, 4096, cache depth; power of two; must equal the attached cache's NUM_ENTRIES
- DATA_WIDTH, 32, word width; must equal the attached cache's DATA_WIDTH
- TIMEOUT, 255, max cycles to wait for mem_ack before aborting; range 1..65535

Ports:
- clk  in  1  clock; all state changes on posedge
- rst  in  1  reset, asynchronous, active-low
- cpu_req  in  1  request strobe; sampled only while cpu_rdy=1
- cpu_we  in  1  1=store, 0=load
- cpu_addr  in  32  word address
- cpu_wdata  in  DATA_WIDTH  store data
- cpu_rdy  out  1  controller idle, can accept a request
- cpu_valid  out  1  one-cycle completion pulse
- cpu_data  out  DATA_WIDTH  load result; valid with cpu_valid
- cpu_err  out  1  completion was aborted; valid with cpu_valid
- c_addr_out  out  32  cache read address
- c_data_out  in  DATA_WIDTH  cache read data, combinational from c_addr_out
- c_we, c_addr_in, c_data_in  out  1/32/DATA_WIDTH  cache write port
- mem_req  out  1  memory request; held until mem_ack or timeout
- mem_we  out  1  memory write; stable while mem_req=1
- mem_addr  out  32  memory address; stable while mem_req=1
- mem_wdata  out  DATA_WIDTH  memory write data; stable while mem_req=1
- mem_ack  in  1  memory done; accepted whenever mem_req=1, including its first cycle
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack
- mem_err  in  1  bus error, valid with mem_ack
- hit_count, miss_count  out  32  statistics counters; see Configuration

## Operation
- Index function: idx(a) = H(a) & (NUM_ENTRIES-1).
  - H computes x=((x>>16)^x)*0x45d9f3b twice, then returns (x>>16)^x.
  - All products are truncated to 32 bits.
- Tag store: tag[NUM_ENTRIES] of 32 bits each, holding the full address. valid[NUM_ENTRIES] is held in flops.
- States:
  - IDLE: cpu_rdy=1. If cpu_req=1, latch addr, we and wdata, then go to LOOKUP.
  - LOOKUP: c_addr_out = latched addr. Hit means valid[idx] && tag[idx]==addr.
    - Load hit: cpu_data<=c_data_out, cpu_valid<=1, go to IDLE.
    - Load miss or any store: go to MEM.
  - MEM: mem_req=1.
    - On mem_ack with mem_err=0: capture data (mem_rdata for loads, wdata for stores), go to FILL.
    - On mem_ack with mem_err=1, or when the timeout counter reaches TIMEOUT: cpu_err<=1, cpu_data<=0, cpu_valid<=1, go to IDLE. No cache or tag update occurs.
  - FILL: c_we=1, c_addr_in=addr, c_data_in=captured data; tag[idx]<=addr, valid[idx]<=1. cpu_data<=captured data (0 for stores), cpu_valid<=1, go to IDLE.
- Stores are write-through with write-allocate and always reach memory, even on a hit.
- Hash collisions show up as tag mismatches. A fill overwrites the colliding entry.
- cpu_req is ignored while cpu_rdy=0. No queuing.
- c_addr_out = latched addr in every state except IDLE, where it is cpu_addr.

## Timing
- Reset values: cpu_rdy=1; cpu_valid=0; cpu_err=0; cpu_data=0; c_we=0; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; all valid[] bits=0; counters=0; state=IDLE.
- Load hit: request accepted at edge 0, LOOKUP during cycle 1, cpu_valid high in cycle 2. A new request may be accepted in that same cycle 2.
- Miss or store: MEM begins in cycle 2. If mem_ack arrives in cycle k, FILL is cycle k+1 and cpu_valid is high in cycle k+2.
- Timeout: counter starts at 0 on entry to MEM and abort fires at count==TIMEOUT.
- c_we is exactly one cycle wide and is asserted only in FILL.
- Reset asserted mid-operation: mem_req and c_we drop immediately, with no completion pulse.

## Configuration
- LIMN2600_CACHE_FILL_STATS_EN defined:
  - hit_count increments on each load hit.
  - miss_count increments on each entry to MEM.
  - Both counters wrap at 2^32.
- Not defined: counter logic is absent and both outputs are tied to 0.

## Test plan
- After reset, load 0x100 with mem_ack 3 cycles after mem_req, mem_rdata=0xDEADBEEF -> mem_req=1, mem_we=0, mem_addr=0x100; c_we pulse with c_data_in=0xDEADBEEF; cpu_valid with cpu_data=0xDEADBEEF, cpu_err=0.
- Repeat load 0x100 -> no mem_req; cpu_valid 2 cycles after acceptance with cpu_data=0xDEADBEEF; with stats on, hit_count=1, miss_count=1.
- Store 0x100 data 0x12345678, mem_ack same cycle as mem_req -> mem_we=1, mem_wdata=0x12345678; c_we=1; then load 0x100 hits and returns 0x12345678.
- Load 0x200 with mem_err=1 on ack -> cpu_valid with cpu_err=1, cpu_data=0; no c_we; reload 0x200 misses again.
- TIMEOUT=4, load with mem_ack never asserted -> mem_req low and cpu_err=1 exactly 4 cycles after entering MEM.
- Reset pulled low during MEM -> mem_req=0 and cpu_rdy=1 at once; a subsequent load of 0x100 misses because valid bits were cleared.

Source files
------------

// File: rtl/limn2600_cache_fill.sv
// Hashed tag lookup and single-outstanding miss/store fill controller for the Limn2600 data cache.
// Optional statistics counters are built when LIMN2600_CACHE_FILL_STATS_EN is defined.
module limn2600_cache_fill #(
   parameter int NUM_ENTRIES = 4096,
   parameter int DATA_WIDTH  = 32,
   parameter int TIMEOUT     = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [31:0]           cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic                  cpu_rdy,
   output logic                  cpu_valid,
   output logic [DATA_WIDTH-1:0] cpu_data,
   output logic                  cpu_err,
   output logic [31:0]           c_addr_out,
   input  logic [DATA_WIDTH-1:0] c_data_out,
   output logic                  c_we,
   output logic [31:0]           c_addr_in,
   output logic [DATA_WIDTH-1:0] c_data_in,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [31:0]           mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_err,
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count
);
   localparam int IDX_W = $clog2(NUM_ENTRIES);

   typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_MEM, S_FILL} state_t;

   state_t                  state_q, state_d;
   logic [31:0]             addr_q, addr_d;
   logic                    we_q, we_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]   fill_q, fill_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [15:0]             tmo_q, tmo_d;
   logic                    cpu_valid_q, cpu_valid_d;
   logic                    cpu_err_q, cpu_err_d;
   logic [DATA_WIDTH-1:0]   cpu_data_q, cpu_data_d;
   logic [NUM_ENTRIES-1:0]  valid_q, valid_d;

   logic [31:0]             tag_mem [NUM_ENTRIES];
   logic [31:0]             tag_rd_q;
   logic [IDX_W-1:0]        cpu_idx;
   logic                    hit;
   logic                    load_hit_evt;
   logic                    miss_evt;

   function automatic logic [31:0] hash32(input logic [31:0] a);
      logic [31:0] x;
      x = a;
      x = ((x >> 16) ^ x) * 32'h045d_9f3b;
      x = ((x >> 16) ^ x) * 32'h045d_9f3b;
      return (x >> 16) ^ x;
   endfunction

   assign cpu_idx = IDX_W'(hash32(cpu_addr));
   assign hit     = valid_q[idx_q] && (tag_rd_q == addr_q);

   // Tag RAM is read while idle so the stored tag is ready when LOOKUP compares it.
   always_ff @(posedge clk) begin
      if (state_q == S_FILL) begin
         tag_mem[idx_q] <= addr_q;
      end
      if (state_q == S_IDLE) begin
         tag_rd_q <= tag_mem[cpu_idx];
      end
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      we_d         = we_q;
      wdata_d      = wdata_q;
      fill_d       = fill_q;
      idx_d        = idx_q;
      tmo_d        = tmo_q;
      cpu_valid_d  = 1'b0;
      cpu_err_d    = 1'b0;
      cpu_data_d   = cpu_data_q;
      valid_d      = valid_q;
      load_hit_evt = 1'b0;
      miss_evt     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cpu_req) begin
               addr_d  = cpu_addr;
               we_d    = cpu_we;
               wdata_d = cpu_wdata;
               idx_d   = cpu_idx;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (!we_q && hit) begin
               cpu_data_d   = c_data_out;
               cpu_valid_d  = 1'b1;
               load_hit_evt = 1'b1;
               state_d      = S_IDLE;
            end else begin
               tmo_d    = '0;
               miss_evt = 1'b1;
               state_d  = S_MEM;
            end
         end
         S_MEM: begin
            // An ack in the last allowed cycle still wins over the abort.
            if (mem_ack && !mem_err) begin
               fill_d  = we_q ? wdata_q : mem_rdata;
               state_d = S_FILL;
            end else if (mem_ack || (tmo_q == 16'(TIMEOUT - 1))) begin
               cpu_err_d   = 1'b1;
               cpu_data_d  = '0;
               cpu_valid_d = 1'b1;
               state_d     = S_IDLE;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         S_FILL: begin
            valid_d[idx_q] = 1'b1;
            cpu_data_d     = we_q ? '0 : fill_q;
            cpu_valid_d    = 1'b1;
            state_d        = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         fill_q      <= '0;
         idx_q       <= '0;
         tmo_q       <= '0;
         cpu_valid_q <= 1'b0;
         cpu_err_q   <= 1'b0;
         cpu_data_q  <= '0;
         valid_q     <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         fill_q      <= fill_d;
         idx_q       <= idx_d;
         tmo_q       <= tmo_d;
         cpu_valid_q <= cpu_valid_d;
         cpu_err_q   <= cpu_err_d;
         cpu_data_q  <= cpu_data_d;
         valid_q     <= valid_d;
      end
   end

   assign cpu_rdy    = (state_q == S_IDLE);
   assign cpu_valid  = cpu_valid_q;
   assign cpu_err    = cpu_err_q;
   assign cpu_data   = cpu_data_q;
   assign c_addr_out = cpu_rdy ? cpu_addr : addr_q;
   assign c_we       = (state_q == S_FILL);
   assign c_addr_in  = addr_q;
   assign c_data_in  = fill_q;
   // Request attributes come straight from the latched request, so they hold for the whole MEM phase.
   assign mem_req    = (state_q == S_MEM);
   assign mem_we     = we_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;

`ifdef LIMN2600_CACHE_FILL_STATS_EN
   logic [31:0] hit_cnt_q, hit_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = hit_cnt_q + 32'(load_hit_evt);
      miss_cnt_d = miss_cnt_q + 32'(miss_evt);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`else
   logic unused_stats;
   assign unused_stats = load_hit_evt ^ miss_evt;
   assign hit_count    = '0;
   assign miss_count   = '0;
`endif

endmodule

// File: tb/tb_limn2600_cache_fill.sv
// Scoreboard bench for limn2600_cache_fill: behavioural cache and memory around the controller.
module tb_limn2600_cache_fill;
   localparam int NE  = 64;
   localparam int DW  = 32;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          cpu_req, cpu_we;
   logic [31:0]   cpu_addr, cpu_wdata;
   logic          cpu_rdy, cpu_valid, cpu_err;
   logic [31:0]   cpu_data;
   logic [31:0]   c_addr_out, c_data_out, c_addr_in, c_data_in;
   logic          c_we;
   logic          mem_req, mem_we, mem_ack, mem_err;
   logic [31:0]   mem_addr, mem_wdata, mem_rdata;
   logic [31:0]   hit_count, miss_count;

   limn2600_cache_fill #(.NUM_ENTRIES(NE), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdy(cpu_rdy), .cpu_valid(cpu_valid), .cpu_data(cpu_data), .cpu_err(cpu_err),
      .c_addr_out(c_addr_out), .c_data_out(c_data_out),
      .c_we(c_we), .c_addr_in(c_addr_in), .c_data_in(c_data_in),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [31:0] data; logic err; } cpu_exp_t;
   typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; } mem_exp_t;
   typedef struct packed { logic [31:0] addr; logic [31:0] data; } fill_exp_t;

   cpu_exp_t  exp_cpu_q [$];
   mem_exp_t  exp_mem_q [$];
   fill_exp_t exp_fill_q [$];

   int vectors = 0;
   int miscompares = 0;

   logic        vvalid [NE];
   logic [31:0] vtag [NE];
   logic [31:0] vdata [NE];
   logic [31:0] mem_arr [logic [31:0]];
   logic [31:0] cache_arr [NE];
   int n_hit = 0;
   int n_miss = 0;

   int   rsp_delay = 0;
   logic rsp_err = 1'b0;
   logic rsp_never = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int unsigned hidx(input logic [31:0] a);
      logic [31:0] x;
      x = a;
      for (int r = 0; r < 2; r++) x = ((x >> 16) ^ x) * 32'h045d9f3b;
      x = (x >> 16) ^ x;
      return x & (NE - 1);
   endfunction

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      if (mem_arr.exists(a)) return mem_arr[a];
      return a ^ 32'hA5C3_0000;
   endfunction

   // Behavioural hashed cache: combinational read, write on posedge.
   always_comb c_data_out = cache_arr[hidx(c_addr_out)];
   always @(posedge clk) if (c_we) cache_arr[hidx(c_addr_in)] <= c_data_in;

   // Memory responder and request checker.
   initial begin
      int          req_cycles;
      logic [31:0] first_addr;
      mem_exp_t    m;
      req_cycles = 0;
      first_addr = '0;
      mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (mem_req) begin
            if (req_cycles == 0) begin
               if (exp_mem_q.size() == 0) begin
                  check_val("mem_req_unexpected", 32'(mem_req), 32'd0);
               end else begin
                  m = exp_mem_q.pop_front();
                  check_val("mem_we", 32'(mem_we), 32'(m.we));
                  check_val("mem_addr", mem_addr, m.addr);
                  if (m.we) check_val("mem_wdata", mem_wdata, m.wdata);
               end
               first_addr = mem_addr;
            end else begin
               check_val("mem_addr_stable", mem_addr, first_addr);
            end
            if (!rsp_never && req_cycles == rsp_delay) begin
               mem_ack   = 1'b1;
               mem_err   = rsp_err;
               mem_rdata = rsp_err ? 32'hBAD0_BAD0 : (mem_we ? 32'h0 : mem_read(mem_addr));
               if (mem_we && !rsp_err) mem_arr[mem_addr] = mem_wdata;
            end else begin
               mem_ack   = 1'b0;
               mem_err   = 1'b0;
               mem_rdata = $urandom;
            end
            req_cycles++;
         end else begin
            mem_ack    = 1'b0;
            mem_err    = 1'b0;
            req_cycles = 0;
         end
      end
   end

   // Completion and fill monitor.
   initial begin
      cpu_exp_t  e;
      fill_exp_t f;
      logic      prev_cwe;
      prev_cwe = 1'b0;
      forever begin
         @(negedge clk);
         if (cpu_valid) begin
            if (exp_cpu_q.size() == 0) begin
               check_val("cpu_valid_unexpected", 32'(cpu_valid), 32'd0);
            end else begin
               e = exp_cpu_q.pop_front();
               check_val("cpu_data", cpu_data, e.data);
               check_val("cpu_err", 32'(cpu_err), 32'(e.err));
               $display("txn done: data=0x%08h err=%0b", cpu_data, cpu_err);
            end
         end
         if (c_we) begin
            check_val("c_we_width", 32'(prev_cwe), 32'd0);
            if (exp_fill_q.size() == 0) begin
               check_val("c_we_unexpected", 32'(c_we), 32'd0);
            end else begin
               f = exp_fill_q.pop_front();
               check_val("c_addr_in", c_addr_in, f.addr);
               check_val("c_data_in", c_data_in, f.data);
            end
         end
         prev_cwe = c_we;
      end
   end

   task automatic check_stats();
`ifdef LIMN2600_CACHE_FILL_STATS_EN
      check_val("hit_count", hit_count, 32'(n_hit));
      check_val("miss_count", miss_count, 32'(n_miss));
`else
      check_val("hit_count_off", hit_count, 32'd0);
      check_val("miss_count_off", miss_count, 32'd0);
`endif
   endtask

   // Issue one request from a negedge with the DUT idle and wait for its completion.
   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int delay, input logic err, input logic never);
      int unsigned ix;
      int          exp_lat;
      int          n;
      logic [31:0] d;
      ix = hidx(addr);
      rsp_delay = delay; rsp_err = err; rsp_never = never;
      if (!we && vvalid[ix] && vtag[ix] == addr) begin
         exp_cpu_q.push_back(cpu_exp_t'{data: vdata[ix], err: 1'b0});
         exp_lat = 2;
         n_hit++;
      end else begin
         exp_mem_q.push_back(mem_exp_t'{we: we, addr: addr, wdata: wdata});
         n_miss++;
         if (never) begin
            exp_cpu_q.push_back(cpu_exp_t'{data: 32'h0, err: 1'b1});
            exp_lat = 2 + TMO;
         end else if (err) begin
            exp_cpu_q.push_back(cpu_exp_t'{data: 32'h0, err: 1'b1});
            exp_lat = 3 + delay;
         end else begin
            d = we ? wdata : mem_read(addr);
            exp_fill_q.push_back(fill_exp_t'{addr: addr, data: d});
            exp_cpu_q.push_back(cpu_exp_t'{data: (we ? 32'h0 : d), err: 1'b0});
            vvalid[ix] = 1'b1; vtag[ix] = addr; vdata[ix] = d;
            exp_lat = 4 + delay;
         end
      end
      $display("txn issue: we=%0b addr=0x%08h wdata=0x%08h delay=%0d err=%0b never=%0b",
               we, addr, wdata, delay, err, never);
      check_val("cpu_rdy_idle", 32'(cpu_rdy), 32'd1);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      @(posedge clk);
      #1;
      cpu_req = 1'b0; cpu_addr = $urandom; cpu_wdata = $urandom;
      n = 0;
      while (n < 40) begin
         @(negedge clk);
         n++;
         if (cpu_valid) break;
      end
      check_val("cpu_valid_seen", 32'(cpu_valid), 32'd1);
      check_val("latency", 32'(n), 32'(exp_lat));
      if (never || err) check_val("mem_req_after_abort", 32'(mem_req), 32'd0);
      check_stats();
   endtask

   task automatic reset_in_mem(input logic [31:0] addr);
      exp_mem_q.push_back(mem_exp_t'{we: 1'b0, addr: addr, wdata: 32'h0});
      rsp_never = 1'b1;
      $display("txn issue: reset during MEM, addr=0x%08h", addr);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr; cpu_wdata = 32'h0;
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      check_val("mem_req_before_rst", 32'(mem_req), 32'd1);
      rst = 1'b0;
      #1;
      check_val("rst_mem_req", 32'(mem_req), 32'd0);
      check_val("rst_cpu_rdy", 32'(cpu_rdy), 32'd1);
      check_val("rst_c_we", 32'(c_we), 32'd0);
      check_val("rst_cpu_valid", 32'(cpu_valid), 32'd0);
      for (int i = 0; i < NE; i++) vvalid[i] = 1'b0;
      n_hit = 0; n_miss = 0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_stats();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] coll;
      logic [31:0] pool [6];
      logic        rw;
      rst = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
      for (int i = 0; i < NE; i++) vvalid[i] = 1'b0;
      mem_arr[32'h100] = 32'hDEAD_BEEF;

      repeat (3) @(negedge clk);
      check_val("rst_cpu_rdy", 32'(cpu_rdy), 32'd1);
      check_val("rst_cpu_valid", 32'(cpu_valid), 32'd0);
      check_val("rst_cpu_err", 32'(cpu_err), 32'd0);
      check_val("rst_cpu_data", cpu_data, 32'h0);
      check_val("rst_c_we", 32'(c_we), 32'd0);
      check_val("rst_mem_req", 32'(mem_req), 32'd0);
      check_val("rst_mem_we", 32'(mem_we), 32'd0);
      check_val("rst_mem_addr", mem_addr, 32'h0);
      check_val("rst_mem_wdata", mem_wdata, 32'h0);
      check_stats();
      rst = 1'b1;
      @(negedge clk);

      do_req(1'b0, 32'h100, 32'h0, 3, 1'b0, 1'b0);            // miss, DEADBEEF
      do_req(1'b0, 32'h100, 32'h0, 0, 1'b0, 1'b0);            // hit
      do_req(1'b1, 32'h100, 32'h1234_5678, 0, 1'b0, 1'b0);    // store, ack same cycle
      do_req(1'b0, 32'h100, 32'h0, 0, 1'b0, 1'b0);            // hit, 12345678
      do_req(1'b0, 32'h200, 32'h0, 1, 1'b1, 1'b0);            // bus error
      do_req(1'b0, 32'h200, 32'h0, 2, 1'b0, 1'b0);            // misses again
      do_req(1'b0, 32'h300, 32'h0, 0, 1'b0, 1'b1);            // timeout

      coll = 32'h101;
      while (hidx(coll) != hidx(32'h100) && coll < 32'h0010_0000) coll++;
      do_req(1'b0, coll, 32'h0, 1, 1'b0, 1'b0);               // evicts 0x100
      do_req(1'b0, 32'h100, 32'h0, 0, 1'b0, 1'b0);            // collision miss

      pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h108;
      pool[3] = 32'h10C; pool[4] = coll;    pool[5] = 32'h200;
      for (int i = 0; i < 30; i++) begin
         rw = 1'($urandom_range(0, 3) == 0);
         do_req(rw, pool[$urandom_range(0, 5)], $urandom, int'($urandom_range(0, 3)),
                1'($urandom_range(0, 7) == 0), 1'b0);
      end

      reset_in_mem(32'h400);
      do_req(1'b0, 32'h100, 32'h0, 1, 1'b0, 1'b0);            // miss after reset
      do_req(1'b0, 32'h100, 32'h0, 0, 1'b0, 1'b0);            // hit

      repeat (2) @(negedge clk);
      check_val("cpu_queue_drained", 32'(exp_cpu_q.size()), 32'd0);
      check_val("mem_queue_drained", 32'(exp_mem_q.size()), 32'd0);
      check_val("fill_queue_drained", 32'(exp_fill_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
